// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word fall-through reads; otherwise data_out is a registered read port.
module param_sync_fifo #(
  parameter int WIDTH         = 8,
  parameter int POINTER       = 4,
  parameter int AFULL_THRESH  = (1 << POINTER) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               rd_en,
  output logic [WIDTH-1:0]   data_out,
  output logic               write_full,
  output logic               read_empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [POINTER:0]   count,
  output logic               overflow,
  output logic               underflow,
  input  logic               clr_err
);

  localparam int DEPTH = 1 << POINTER;
  localparam logic [POINTER:0] DEPTH_C  = (POINTER+1)'(DEPTH);
  localparam logic [POINTER:0] AFULL_C  = (POINTER+1)'(AFULL_THRESH);
  localparam logic [POINTER:0] AEMPTY_C = (POINTER+1)'(AEMPTY_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [POINTER:0] wr_ptr;
  logic [POINTER:0] rd_ptr;
  logic [POINTER:0] count_q;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = rd_en && !read_empty;
  assign push_ok = wr_en && (!write_full || pop_ok);

  // Flags decode from the count register only
  assign count        = count_q;
  assign write_full   = (count_q == DEPTH_C);
  assign read_empty   = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[POINTER-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
      // A rejection in the same cycle as clr_err keeps the flag set
      if (wr_en && !push_ok) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en && !pop_ok) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out = mem[rd_ptr[POINTER-1:0]];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (pop_ok) begin
      data_out <= mem[rd_ptr[POINTER-1:0]];
    end
  end
`endif

  // The extra pointer bit makes the pointer distance equal the occupancy
  ptr_count_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    count_q == (wr_ptr - rd_ptr));

endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomised and directed bench for param_sync_fifo, checked against a queue-based reference model.
module tb_param_sync_fifo;

  localparam int WIDTH = 8;
  localparam int POINTER = 4;
  localparam int DEPTH = 1 << POINTER;
  localparam int AFT = 14;
  localparam int AET = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             rd_en = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             write_full, read_empty, almost_full, almost_empty;
  logic [POINTER:0] count;
  logic             overflow, underflow;

  int n_vec = 0;
  int n_err = 0;

  int q[$];
  int dout_m = 0;
  bit ovf_m = 0;
  bit udf_m = 0;

  param_sync_fifo #(
    .WIDTH(WIDTH), .POINTER(POINTER), .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .write_full(write_full), .read_empty(read_empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("count", int'(count), q.size());
    chk("write_full", int'(write_full), int'(q.size() == DEPTH));
    chk("read_empty", int'(read_empty), int'(q.size() == 0));
    chk("almost_full", int'(almost_full), int'(q.size() >= AFT));
    chk("almost_empty", int'(almost_empty), int'(q.size() <= AET));
    chk("overflow", int'(overflow), int'(ovf_m));
    chk("underflow", int'(underflow), int'(udf_m));
`ifdef FIFO_FWFT_EN
    if (q.size() != 0) chk("data_out", int'(data_out), q[0]);
`else
    chk("data_out", int'(data_out), dout_m);
`endif
  endtask

  // Applies one cycle of requests, advances the model, then checks after the edge
  task automatic cycle(input bit wr, input int din, input bit rd, input bit clr);
    bit pop_ok, push_ok;
    wr_en = wr; data_in = WIDTH'(din); rd_en = rd; clr_err = clr;
    @(posedge clk);
    #1;
    pop_ok  = rd && (q.size() > 0);
    push_ok = wr && ((q.size() < DEPTH) || pop_ok);
    if (pop_ok) dout_m = q.pop_front();
    if (push_ok) q.push_back(din & 'hFF);
    if (wr && !push_ok) ovf_m = 1; else if (clr) ovf_m = 0;
    if (rd && !pop_ok) udf_m = 1; else if (clr) udf_m = 0;
    wr_en = 0; rd_en = 0; clr_err = 0;
    check_all();
  endtask

  task automatic do_reset();
    wr_en = 0; rd_en = 0; clr_err = 0;
    rst_n = 1'b0;
    #2;
    q.delete(); dout_m = 0; ovf_m = 0; udf_m = 0;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    #3;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill, then drain in order
    for (int i = 0; i < 16; i++) cycle(1, 'h0A + i, 0, 0);
    chk("full_after_fill", int'(write_full), 1);
    // Push into full FIFO is rejected
    cycle(1, 'hFF, 0, 0);
    chk("ovf_set", int'(overflow), 1);
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0);
    chk("empty_after_drain", int'(read_empty), 1);

    // Simultaneous push/pop on empty FIFO
    cycle(1, 'h55, 1, 0);
    chk("udf_set", int'(underflow), 1);
    cycle(0, 0, 1, 1);

    // Full FIFO with continuous push+pop across pointer wrap
    for (int i = 0; i < 16; i++) cycle(1, i, 0, 0);
    for (int i = 0; i < 40; i++) cycle(1, 16 + i, 1, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0);

    // Reset in the middle of a burst
    for (int i = 0; i < 5; i++) cycle(1, 'h20 + i, 0, 0);
    @(posedge clk);
    #1;
    wr_en = 1; data_in = 'h99;
    do_reset();
    cycle(1, 'h33, 0, 0);
    cycle(0, 0, 1, 0);

    // Single word into empty FIFO, observed before and after the pop
    cycle(1, 'h7E, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);

    // Random traffic with occasional clears and resets
    for (int i = 0; i < 3000; i++) begin
      int mode;
      bit wr, rd;
      mode = int'(i / 500) % 3;
      wr = ($urandom_range(99) < (mode == 0 ? 70 : (mode == 1 ? 30 : 50)));
      rd = ($urandom_range(99) < (mode == 0 ? 30 : (mode == 1 ? 70 : 50)));
      if ($urandom_range(999) == 0) do_reset();
      else cycle(wr, int'($urandom_range(255)), rd, $urandom_range(19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
